// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART stream FIFO slice.
package uart_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Read-mode encodings for the FWFT parameter
  localparam int unsigned MODE_REG  = 0;
  localparam int unsigned MODE_FWFT = 1;

  // Count width able to hold 0..depth inclusive
  function automatic int unsigned cw_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_stream_fifo_if.sv
// Handshake, status and diagnostic bundle for uart_stream_fifo.
interface uart_stream_fifo_if #(
  parameter int unsigned WIDTH = uart_fifo_pkg::DEF_WIDTH,
  parameter int unsigned CW    = uart_fifo_pkg::cw_of(uart_fifo_pkg::DEF_DEPTH)
);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    af_thresh;
  logic [CW-1:0]    ae_thresh;
  logic [CW-1:0]    fill_count;
  logic [CW-1:0]    max_fill;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           fill_count, max_fill, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           fill_count, max_fill, overflow, underflow
  );

endinterface

// File: rtl/uart_stream_fifo_dpram.sv
// Simple dual-port storage: synchronous write, registered or combinational read.
module fifo_dpram
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned FWFT  = MODE_REG,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is not reset; only the read register is
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign o_rd_data = r_mem[i_rd_addr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_rd_data;

      // Holds last popped word between reads
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_data <= '0;
        end else if (i_rd_en) begin
          r_rd_data <= r_mem[i_rd_addr];
        end
      end

      assign o_rd_data = r_rd_data;
    end
  endgenerate

endmodule

// File: rtl/uart_stream_fifo.sv
// Parametrised byte FIFO for the UART datapath with programmable almost flags,
// flush, sticky error flags and a high-water-mark counter.
module uart_stream_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned FWFT  = MODE_REG,
  parameter int unsigned CW    = cw_of(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  uart_stream_fifo_if.slave bus
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]    r_fill, r_max, w_fill_nxt, w_max_nxt;
  logic             r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
  logic             w_full, w_empty, w_wr_fire, w_rd_fire;
  logic [WIDTH-1:0] w_rd_data;

  // Flags are pure compares of the registered count so they never lag it
  assign w_full    = (r_fill == DEPTH_C);
  assign w_empty   = (r_fill == '0);
  assign w_wr_fire = bus.wr_en & ~w_full  & ~bus.flush;
  assign w_rd_fire = bus.rd_en & ~w_empty & ~bus.flush;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_fill_nxt   = r_fill;
    w_max_nxt    = r_max;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;

    if (bus.flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_fill_nxt   = '0;
    end else begin
      if (w_wr_fire) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_rd_fire) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      case ({w_wr_fire, w_rd_fire})
        2'b10:   w_fill_nxt = r_fill + CW'(1);
        2'b01:   w_fill_nxt = r_fill - CW'(1);
        default: w_fill_nxt = r_fill;
      endcase
    end

    // Error clear yields to a same-cycle set condition
    w_ovf_nxt = (bus.wr_en & w_full  & ~bus.flush) | (r_ovf & ~bus.err_clr);
    w_unf_nxt = (bus.rd_en & w_empty & ~bus.flush) | (r_unf & ~bus.err_clr);

    if (bus.err_clr || (w_fill_nxt > r_max)) begin
      w_max_nxt = w_fill_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_max    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_fill   <= w_fill_nxt;
      r_max    <= w_max_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_fire),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_valid_fwft
      assign bus.rd_valid = ~w_empty;
    end else begin : g_valid_reg
      logic r_rd_valid;

      // One-cycle pulse tracking the registered read data
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_fire;
        end
      end

      assign bus.rd_valid = r_rd_valid;
    end
  endgenerate

  assign bus.rd_data      = w_rd_data;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_fill >= bus.af_thresh);
  assign bus.almost_empty = (r_fill <= bus.ae_thresh);
  assign bus.fill_count   = r_fill;
  assign bus.max_fill     = r_max;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule

// File: doc/uart_stream_fifo.md
Name: uart_stream_fifo

Overview:
Parametrised next-generation byte FIFO for the UART datapath, sitting between uart_rx and uart_tx or the host-side register interface. It generalises the earlier ring buffer in several ways:
- width and depth are parameters;
- read mode is selectable: registered read or first-word-fall-through;
- almost-full and almost-empty thresholds are programmable at runtime;
- it adds synchronous flush, sticky overflow/underflow error flags and a high-water-mark counter for link diagnostics.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of storage entries; must be a power of 2 and at least 4.
- FWFT, 0, read mode. 0 = registered read: rd_data is valid the cycle after rd_en, flagged by rd_valid. 1 = first-word-fall-through: rd_data shows the oldest word whenever empty=0.
- CW, $clog2(DEPTH)+1, width of counts and thresholds.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  FWFT=0: pulses high the cycle after an accepted read. FWFT=1: equals ~empty.
- full  out  1  fill_count == DEPTH.
- empty  out  1  fill_count == 0.
- almost_full  out  1  fill_count >= af_thresh.
- almost_empty  out  1  fill_count <= ae_thresh.
- af_thresh  in  CW  almost-full threshold, runtime programmable.
- ae_thresh  in  CW  almost-empty threshold, runtime programmable.
- fill_count  out  CW  number of stored words, 0..DEPTH.
- max_fill  out  CW  highest fill_count seen since reset or err_clr.
- overflow  out  1  sticky; set on wr_en while full.
- underflow  out  1  sticky; set on rd_en while empty.
- err_clr  in  1  clears overflow, underflow and max_fill.

Behaviour:
- Reset (async, rst=1) values:
  - pointers = 0, fill_count = 0, max_fill = 0;
  - rd_valid = 0, rd_data = 0, overflow = 0, underflow = 0;
  - empty = 1, full = 0;
  - almost flags are evaluated from fill_count = 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- fill_count is a registered CW-bit counter. full, empty, almost_full and almost_empty are combinational compares of the registered fill_count, so they are always consistent with it in the same cycle.
- Handshake: wr_fire = wr_en & ~full; rd_fire = rd_en & ~empty. Both are evaluated against the current-cycle flags.
- Write while full is dropped, even if a read fires in the same cycle. The stored word is not modified.
- fill_count update:
  - +1 on wr_fire only;
  - -1 on rd_fire only;
  - unchanged when both fire or neither fires.
  - It never exceeds DEPTH and never goes below 0.
- Simultaneous read and write on an empty FIFO: the read is rejected (empty=1) and the write is accepted; fill_count becomes 1.
- Read mode FWFT=0:
  - on rd_fire, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next cycle;
  - otherwise rd_valid <= 0 and rd_data holds its last value;
  - read latency is 1 cycle.
- Read mode FWFT=1:
  - rd_data = mem[rd_ptr] combinationally and rd_valid = ~empty;
  - rd_fire pops the word and the next word appears on the following cycle;
  - a word written into an empty FIFO appears on rd_data the cycle after the write.
- flush:
  - has priority over wr_en and rd_en in the same cycle; both are ignored;
  - next cycle: pointers = 0, fill_count = 0, rd_valid = 0;
  - memory contents, overflow, underflow and max_fill are left unchanged.
- overflow <= 1 when wr_en & full & ~flush. underflow <= 1 when rd_en & empty & ~flush.
- max_fill <= fill_count_next whenever fill_count_next > max_fill.
- err_clr clears overflow, underflow and max_fill. If a set condition occurs in the same cycle, set wins and max_fill loads fill_count_next.
- Thresholds are sampled combinationally every cycle; changing them updates the almost flags the same cycle. af_thresh = 0 forces almost_full = 1. ae_thresh >= DEPTH forces almost_empty = 1.
- Reset asserted mid-operation: all state returns to reset values immediately (async). The first write after rst deasserts is accepted normally.

Decomposition:
- Shared package uart_fifo_pkg holds:
  - default WIDTH and DEPTH constants;
  - a CW helper function;
  - the read-mode encodings MODE_REG = 0 and MODE_FWFT = 1.
- One sub-module, fifo_dpram: a simple dual-port memory with a synchronous write and a read port that is either registered or combinational depending on FWFT.
- Pointer, count, flag and diagnostic logic stay in uart_stream_fifo.

Test Plan (all scenarios use DEPTH=16, WIDTH=8):
- Fill/drain, FWFT=0: write 0x00..0x0F on consecutive cycles -> full=1, fill_count=16, almost_full=1 with af_thresh=14. Then read 16 times -> rd_valid pulses, rd_data = 0x00..0x0F in order one cycle after each rd_en, empty=1 at end.
- Overflow/underflow: 17th write when full -> overflow=1 and the stored data is unchanged. rd_en on an empty FIFO -> underflow=1 and rd_valid stays 0. Pulse err_clr -> both flags = 0 and max_fill = 0.
- Simultaneous read and write at fill_count=8 for 20 cycles -> fill_count stays 8, output sequence is continuous, and the pointers wrap past 15 without data loss.
- FWFT=1: write 0xA5 into an empty FIFO -> rd_data=0xA5 and rd_valid=1 the next cycle with no rd_en. rd_en -> empty=1 the next cycle.
- flush at fill_count=5 with wr_en=1 in the same cycle -> fill_count=0 and empty=1 next cycle, the write is ignored, and max_fill stays 5.
- Async rst asserted mid-burst (fill_count=9) for 1 cycle -> all outputs at reset values immediately. The next write of 0x3C is read back as 0x3C.
